// File: rtl/nois_mem_arb_pkg.sv
// Shared types and default widths for the two-master on-chip memory arbiter.
// The grant FSM state type lives here so the top and the bench agree on encoding.
package nois_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/nois_rr_pick2.sv
// Two-way round-robin pick: on a tie the master that was not granted last wins.
module nois_rr_pick2
    import nois_mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    assign winner_o = req1_i & (~req0_i | ~last_grant_i);

endmodule

// File: rtl/nois_system_onchip_mem_arbiter.sv
// Arbitrates two Avalon-style masters onto one single-port RAM with bounded
// bursts per grant and one-cycle read return to the owning master.
module nois_system_onchip_mem_arbiter
    import nois_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic [3:0]        burst_cnt_q;
    logic              rvld0_q;
    logic              rvld1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata0_d;
    logic [DATA_W-1:0] rdata1_d;

    logic req0;
    logic req1;
    logic acc0;
    logic acc1;
    logic burst_last;
    logic pick_valid;
    logic pick_win;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign acc0       = (state_q == GNT0) & req0;
    assign acc1       = (state_q == GNT1) & req1;
    assign burst_last = (burst_cnt_q + 4'd1) == BURST_LIM;

    nois_rr_pick2 u_pick (
        .req0_i       (req0),
        .req1_i       (req1),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_win)
    );

    // Grant FSM; a grant ends on burst limit or when its owner drops the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    burst_cnt_q <= '0;
                    if (pick_valid) begin
                        state_q <= pick_win ? GNT1 : GNT0;
                    end
                end
                GNT0: begin
                    if (req0 && !burst_last) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else begin
                        state_q      <= req1 ? GNT1 : IDLE;
                        last_grant_q <= 1'b0;
                        burst_cnt_q  <= '0;
                    end
                end
                GNT1: begin
                    if (req1 && !burst_last) begin
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else begin
                        state_q      <= req0 ? GNT0 : IDLE;
                        last_grant_q <= 1'b1;
                        burst_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        if (state_q == GNT1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect = acc0 | acc1;
    assign mem_write      = (acc0 & m0_write) | (acc1 & m1_write);
    assign m0_waitrequest = ~acc0;
    assign m1_waitrequest = ~acc1;

    // Read data passes straight through in the valid cycle and is then held.
    assign rdata0_d = rvld0_q ? mem_readdata : rdata0_q;
    assign rdata1_d = rvld1_q ? mem_readdata : rdata1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvld0_q  <= 1'b0;
            rvld1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvld0_q  <= acc0 & m0_read & ~m0_write;
            rvld1_q  <= acc1 & m1_read & ~m1_write;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_readdata      = rdata0_d;
    assign m1_readdata      = rdata1_d;
    assign m0_readdatavalid = rvld0_q;
    assign m1_readdatavalid = rvld1_q;

endmodule

// File: doc/nois_system_onchip_mem_arbiter.md
NOIS_SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: nois_system_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, shall set the word-address width on both master ports and on the memory port.
REQ-002 Parameter DATA_W, default 32, shall set the data width; byteenable width shall be DATA_W/8.
REQ-003 Parameter MAX_BURST, default 4, shall set the maximum number of consecutive accepted transfers per grant, with a legal range of 1..15.
REQ-004 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  shall be the reset: asynchronous, active-high.
REQ-006 mN_address  in  ADDR_W  shall be the master N word address, for N=0,1.
REQ-007 mN_byteenable  in  DATA_W/8  shall be the master N byte lanes.
REQ-008 mN_read / mN_write  in  1 each  shall be the master N read and write requests.
REQ-009 mN_writedata  in  DATA_W  shall be the master N write data.
REQ-010 mN_waitrequest  out  1  shall mean that the request of master N is not accepted in this cycle.
REQ-011 mN_readdata  out  DATA_W  shall carry read data to master N.
REQ-012 mN_readdatavalid  out  1  shall mark a valid mN_readdata.
REQ-013 mem_address, mem_byteenable, mem_writedata  out  shall drive the single-port RAM with the granted master's fields.
REQ-014 mem_chipselect / mem_write  out  1 each  shall be the RAM select and write enable.
REQ-015 mem_readdata  in  DATA_W  shall be the RAM output, valid exactly one cycle after an accepted read address.

Function
REQ-016 The FSM shall have exactly three states: IDLE, GNT0, GNT1.
REQ-017 Requests in IDLE: one master requesting -> GNT of that master next cycle; both requesting -> GNT of the master that is not last_grant; no request -> stay in IDLE.
REQ-018 In GNTn, when master n requests, mn_waitrequest shall be 0, the transfer is accepted that cycle, mem_chipselect shall be 1, and master n's fields shall drive the memory port combinationally.
REQ-019 Every master not currently accepted shall see waitrequest=1, including in IDLE (one-cycle arbitration latency).
REQ-020 burst_cnt (4 bits) shall increment on each accepted transfer and clear on every state change.
REQ-021 GNTn shall be left after an accept cycle with burst_cnt+1 == MAX_BURST, or on a cycle where master n drops its request: go to GNT of the other master if it requests, else IDLE; last_grant<=n on exit.
REQ-022 At MAX_BURST, when only master n is requesting, the FSM shall pass through IDLE for one cycle and then re-grant n.
REQ-023 mem_write shall equal the accepted master's write; read and write asserted together shall be treated as a write, with the read ignored and no readdatavalid.
REQ-024 An accepted read shall register rd_owner=n; on the next cycle mn_readdatavalid=1 and mn_readdata=mem_readdata; the other master's readdatavalid stays 0.
REQ-025 Back-to-back reads shall return one datum per cycle, in order, with fixed latency 1.
REQ-026 mN_readdata shall hold its last value when readdatavalid=0.
REQ-027 No cycle shall accept transfers from both masters, and no memory access shall occur without an accept.

Reset
REQ-028 On reset assertion, asynchronously: state=IDLE, last_grant=1 (master 0 wins first tie), burst_cnt=0, both readdatavalid=0, both readdata=0, both waitrequest=1, mem_chipselect=0, mem_write=0.
REQ-029 A read accepted in the cycle reset asserts shall produce no readdatavalid after reset.

Structure
REQ-030 The state enum and the ADDR_W/DATA_W defaults shall live in shared package nois_mem_arb_pkg.
REQ-031 The round-robin selection (two requests plus last_grant -> winner) shall be one natural sub-module, nois_rr_pick2; everything else shall be flat.

Verification
REQ-032 Reset, then m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 -> m0_waitrequest=1 in the IDLE cycle; write accepted in GNT0; readdatavalid=1 with 0xDEADBEEF exactly one cycle after the read is accepted.
REQ-033 Both masters request reads continuously from reset, MAX_BURST=4 -> accept pattern m0 x4, m1 x4, m0 x4, with each readdatavalid only on its owner.
REQ-034 Only m1 requests 10 reads, MAX_BURST=4 -> 4 accepts, 1 IDLE cycle, 4 accepts, 1 IDLE cycle, 2 accepts.
REQ-035 m0 writes byteenable 0x3 with data 0x1111_2222 over 0xAAAA_BBBB at address 0x3FF (top address), then reads -> 0xAAAA_2222.
REQ-036 m1 asserts read and write together at 0x010 -> memory written; no m1_readdatavalid.
REQ-037 Reset asserted mid-burst, in the cycle after a read is accepted -> all outputs take their REQ-028 values immediately; no readdatavalid; after release, m0 wins the first tie.
